// File: rtl/rsc_encoder_if.sv
// Handshake bundle between the RSC encoder and its bit source / symbol sink.
// The master side drives the data bits and accepts the symbol pairs; the encoder is the slave.
interface rsc_encoder_if;
  logic               in_valid;
  logic               in_ready;
  logic               in_bit;
  logic               out_valid;
  logic               out_ready;
  logic               sys_bit;
  logic               par_bit;
  logic signed [15:0] sys_sym;
  logic signed [15:0] par_sym;
  logic               out_tail;
  logic               out_last;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, sys_bit, par_bit, sys_sym, par_sym, out_tail, out_last
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, sys_bit, par_bit, sys_sym, par_sym, out_tail, out_last
  );
endinterface

// File: rtl/rsc_encoder.sv
// Rate-1/2 recursive systematic convolutional encoder (feedback 7, feedforward 5 octal)
// with two trellis-termination tail steps per frame and bipolar 16-bit symbol output.
module rsc_encoder #(
  parameter int                 FRAME_LEN = 16,
  parameter logic signed [15:0] AMP       = 16'sd1024
) (
  input logic          clk,
  input logic          rst_n,
  rsc_encoder_if.slave bus
);

  localparam int            CW        = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] LAST_TAIL = CW'(1);

  typedef enum logic {DATA, TAIL} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               s1_q, s1_d, s2_q, s2_d;
  logic               valid_q, valid_d;
  logic               sys_q, sys_d, par_q, par_d;
  logic               tail_q, tail_d, last_q, last_d;
  logic signed [15:0] sys_sym_q, sys_sym_d, par_sym_q, par_sym_d;

  logic slot_free, in_ready_c, step, u, a, p;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    valid_d   = valid_q;
    sys_d     = sys_q;
    par_d     = par_q;
    tail_d    = tail_q;
    last_d    = last_q;
    sys_sym_d = sys_sym_q;
    par_sym_d = par_sym_q;

    slot_free  = !valid_q || bus.out_ready;
    in_ready_c = (state_q == DATA) && slot_free;
    step       = (state_q == DATA) ? (bus.in_valid && in_ready_c) : slot_free;
    // Tail input u = s1^s2 cancels the feedback so a=0 and the state flushes to zero.
    u = (state_q == DATA) ? bus.in_bit : (s1_q ^ s2_q);
    a = u ^ s1_q ^ s2_q;
    p = a ^ s2_q;

    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

    if (step) begin
      s1_d      = a;
      s2_d      = s1_q;
      valid_d   = 1'b1;
      sys_d     = u;
      par_d     = p;
      sys_sym_d = u ? -AMP : AMP;
      par_sym_d = p ? -AMP : AMP;
      tail_d    = (state_q == TAIL);
      last_d    = (state_q == TAIL) && (cnt_q == LAST_TAIL);

      if (state_q == DATA) begin
        if (cnt_q == LAST_DATA) begin
          state_d = TAIL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        if (cnt_q == LAST_TAIL) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DATA;
      cnt_q     <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      valid_q   <= 1'b0;
      sys_q     <= 1'b0;
      par_q     <= 1'b0;
      tail_q    <= 1'b0;
      last_q    <= 1'b0;
      sys_sym_q <= '0;
      par_sym_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      valid_q   <= valid_d;
      sys_q     <= sys_d;
      par_q     <= par_d;
      tail_q    <= tail_d;
      last_q    <= last_d;
      sys_sym_q <= sys_sym_d;
      par_sym_q <= par_sym_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.sys_bit   = sys_q;
  assign bus.par_bit   = par_q;
  assign bus.sys_sym   = sys_sym_q;
  assign bus.par_sym   = par_sym_q;
  assign bus.out_tail  = tail_q;
  assign bus.out_last  = last_q;

endmodule

// File: tb/tb_rsc_encoder.sv
// Self-checking bench for rsc_encoder: hand-derived frame vectors, stall/reset/back-to-back
// sequences, and randomized frames scored against a polynomial-level reference model.
module tb_rsc_encoder;

  localparam int FL = 4;

  typedef struct {
    bit               sysBit;
    bit               parBit;
    bit               tail;
    bit               last;
    logic signed [15:0] sysSym;
    logic signed [15:0] parSym;
  } pair_t;

  // Frame bits are sent LSB first; sys/par hold pair k in bit k.
  typedef struct {
    bit [FL-1:0]   frame;
    bit [FL+1:0]   expSys;
    bit [FL+1:0]   expPar;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   pairCount;
  int   readyMode;
  bit   monEnable;
  bit   manualReady;
  pair_t expQ[$];
  bit    aHist[$];
  vec_t  vecs[4];

  rsc_encoder_if ifc ();

  rsc_encoder #(.FRAME_LEN(FL), .AMP(16'sd1024)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [15:0] symOf(input bit b);
    return b ? -16'sd1024 : 16'sd1024;
  endfunction

  function automatic logic [63:0] packPair(input pair_t pr);
    return {28'd0, pr.sysBit, pr.parBit, pr.tail, pr.last, pr.sysSym, pr.parSym};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushTable(input vec_t v);
    pair_t pr;
    for (int k = 0; k < FL + 2; k++) begin
      pr.sysBit = v.expSys[k];
      pr.parBit = v.expPar[k];
      pr.tail   = (k >= FL);
      pr.last   = (k == FL + 1);
      pr.sysSym = symOf(v.expSys[k]);
      pr.parSym = symOf(v.expPar[k]);
      expQ.push_back(pr);
    end
  endtask

  // Feedback polynomial 1+D+D^2 over the history of a, feedforward 1+D^2.
  task automatic modelFrame(input bit [FL-1:0] frame);
    pair_t pr;
    bit u, a, p, d1, d2;
    for (int k = 0; k < FL + 2; k++) begin
      d1 = aHist[aHist.size() - 1];
      d2 = aHist[aHist.size() - 2];
      u  = (k < FL) ? frame[k] : (d1 ^ d2);
      a  = u ^ d1 ^ d2;
      p  = a ^ d2;
      aHist.push_back(a);
      if (aHist.size() > 8) aHist.delete(0);
      pr.sysBit = u;
      pr.parBit = p;
      pr.tail   = (k >= FL);
      pr.last   = (k == FL + 1);
      pr.sysSym = symOf(u);
      pr.parSym = symOf(p);
      expQ.push_back(pr);
    end
  endtask

  task automatic applyStimulus(input bit [FL-1:0] frame, input int n, input bit randValid);
    bit acc;
    int guard;
    for (int i = 0; i < n; i++) begin
      if (randValid) begin
        while ($urandom_range(0, 3) == 0) begin
          ifc.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      ifc.in_valid = 1'b1;
      ifc.in_bit   = frame[i];
      guard = 0;
      forever begin
        @(negedge clk);
        acc = ifc.in_ready;
        @(posedge clk);
        #1;
        if (acc) break;
        guard++;
        if (guard > 200) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept_timeout: bit %0d never accepted", i);
          break;
        end
      end
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int g;
    g = 0;
    while (expQ.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d pairs outstanding, required 0", expQ.size());
      expQ.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Sink side: out_ready pattern chosen by the current test phase.
  always @(posedge clk) begin
    #2;
    case (readyMode)
      0:       ifc.out_ready = 1'b1;
      1:       ifc.out_ready = ($urandom_range(0, 3) != 0);
      default: ifc.out_ready = manualReady;
    endcase
  end

  // Scoreboard: every transfer pops the head; a stalled pair must equal the head and block input.
  always @(negedge clk) begin
    if (monEnable && rst_n && ifc.out_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pair: got sys=%0b par=%0b, required no pair", ifc.sys_bit, ifc.par_bit);
      end else begin
        checkOutput(ifc.out_ready ? "pair" : "held_pair",
                    {28'd0, ifc.sys_bit, ifc.par_bit, ifc.out_tail, ifc.out_last, ifc.sys_sym, ifc.par_sym},
                    packPair(expQ[0]));
        if (!ifc.out_ready) begin
          checkOutput("in_ready_stall", {63'd0, ifc.in_ready}, 64'd0);
        end else begin
          expQ.delete(0);
          pairCount++;
        end
      end
    end
  end

  initial begin
    bit [FL-1:0] rf;
    int base;
    int g;

    checks      = 0;
    errors      = 0;
    pairCount   = 0;
    readyMode   = 0;
    monEnable   = 1'b0;
    manualReady = 1'b1;
    aHist       = '{1'b0, 1'b0};
    ifc.in_valid = 1'b0;
    ifc.in_bit   = 1'b0;

    vecs[0] = '{frame: 4'b0001, expSys: 6'b110001, expPar: 6'b100111};
    vecs[1] = '{frame: 4'b0000, expSys: 6'b000000, expPar: 6'b000000};
    vecs[2] = '{frame: 4'b1111, expSys: 6'b111111, expPar: 6'b101101};
    vecs[3] = '{frame: 4'b1010, expSys: 6'b101010, expPar: 6'b110110};

    rst_n = 1'b0;
    #12;
    checkOutput("reset_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    checkOutput("reset_out_tail",  {63'd0, ifc.out_tail},  64'd0);
    checkOutput("reset_out_last",  {63'd0, ifc.out_last},  64'd0);
    checkOutput("reset_bits",      {62'd0, ifc.sys_bit, ifc.par_bit}, 64'd0);
    checkOutput("reset_syms",      {32'd0, ifc.sys_sym, ifc.par_sym}, 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    monEnable = 1'b1;

    $display("[TB] table vectors");
    for (int v = 0; v < 4; v++) begin
      pushTable(vecs[v]);
      applyStimulus(vecs[v].frame, FL, 1'b0);
      waitDrain();
    end

    $display("[TB] stall after second pair");
    readyMode   = 2;
    manualReady = 1'b1;
    base = pairCount;
    pushTable(vecs[0]);
    fork
      applyStimulus(vecs[0].frame, FL, 1'b0);
      begin
        g = 0;
        while (pairCount < base + 2 && g < 100) begin
          @(posedge clk);
          #1;
          g++;
        end
        manualReady = 1'b0;
        repeat (3) @(posedge clk);
        manualReady = 1'b1;
      end
    join
    waitDrain();
    checkOutput("stall_pair_count", 64'(pairCount - base), 64'(FL + 2));
    readyMode = 0;

    $display("[TB] back-to-back frames with tail in_ready check");
    for (int f = 0; f < 2; f++) begin
      pushTable(vecs[0]);
      applyStimulus(vecs[0].frame, FL, 1'b0);
      ifc.in_valid = 1'b1;
      ifc.in_bit   = 1'b1;
      for (int t = 0; t < 2; t++) begin
        @(negedge clk);
        checkOutput("tail_in_ready", {63'd0, ifc.in_ready}, 64'd0);
      end
      ifc.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    waitDrain();

    $display("[TB] asynchronous reset mid-frame");
    monEnable = 1'b0;
    applyStimulus(vecs[0].frame, 2, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    checkOutput("midreset_sys_sym",   {48'd0, ifc.sys_sym},   64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    expQ.delete();
    aHist = '{1'b0, 1'b0};
    @(posedge clk);
    #1;
    monEnable = 1'b1;
    pushTable(vecs[0]);
    applyStimulus(vecs[0].frame, FL, 1'b0);
    waitDrain();

    $display("[TB] randomized frames");
    readyMode = 1;
    for (int f = 0; f < 1000; f++) begin
      rf = FL'($urandom);
      modelFrame(rf);
      applyStimulus(rf, FL, 1'b1);
    end
    readyMode = 0;
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsc_encoder.md
Name: rsc_encoder

Overview:
- Rate-1/2 recursive systematic convolutional (RSC) encoder, memory 2, generators (feedback 7, feedforward 5) octal.
- Transmit-side counterpart of the MAP decoder chain. Encodes fixed-length frames, appends 2 trellis-termination tail steps, and emits systematic/parity bits plus bipolar signed 16-bit symbols.
- The symbols feed the channel model and decoder bench directly.

Parameters:
- FRAME_LEN, 16, data bits per frame (>=1).
- AMP, 16'sd1024, symbol magnitude. Bit 0 maps to +AMP, bit 1 maps to -AMP.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_bit is valid
- in_ready  output  1  encoder accepts in_bit this cycle
- in_bit  input  1  data bit
- out_valid  output  1  output slot holds a symbol pair
- out_ready  input  1  downstream accepts the pair
- sys_bit  output  1  systematic bit
- par_bit  output  1  parity bit
- sys_sym  output  16 signed  bipolar systematic symbol
- par_sym  output  16 signed  bipolar parity symbol
- out_tail  output  1  current pair is a tail step
- out_last  output  1  final pair of the frame (second tail step)

Behaviour:
- Reset (async, rst_n=0):
  - Encoder state s1=s2=0, bit counter=0, FSM=DATA.
  - out_valid=0, all output data=0, out_tail=0, out_last=0.
  - A reset mid-frame discards the partial frame. The next accepted bit is bit 0 of a new frame.
- Encoder step for input u, state (s1,s2):
  - a = u^s1^s2
  - p = a^s2
  - next s1=a, next s2=s1
  - emit sys=u, par=p
- FSM DATA:
  - in_ready = (FSM==DATA) && (!out_valid || out_ready).
  - On in_valid&&in_ready: perform the step with u=in_bit, load the output register, increment the counter.
  - When the accepted bit is the FRAME_LEN-th: go to TAIL, counter=0.
- FSM TAIL (2 steps):
  - in_ready=0.
  - Whenever the output slot is free (!out_valid || out_ready), perform the step with u=s1^s2. This forces a=0 and drives the state to zero after 2 steps.
  - Set out_tail=1. Set out_last=1 on the second step.
  - After the second step, return to DATA. The state is then 0 by construction.
- Output register, one stage:
  - Data is registered. Latency is 1 cycle from the accepted input (or the tail step) to out_valid.
  - out_valid is set on load and cleared on out_valid&&out_ready with no new load. Simultaneous drain and load is allowed, so throughput is 1 pair/cycle.
  - While out_valid&&!out_ready, every output holds stable and no step occurs.
- Symbols: sys_sym = sys_bit ? -AMP : AMP, and likewise for par_sym. Both are registered together with the bits.
- Counter width: $clog2(FRAME_LEN+1). FRAME_LEN=1 is legal: 1 data step followed immediately by 2 tail steps.
- Encoder state is never cleared between frames except by reset. Termination guarantees it is zero.

Test Plan:
1. Reset, FRAME_LEN=4, out_ready=1, inputs 1,0,0,0 back-to-back.
   - Required: sys 1,0,0,0,1,1; par 1,1,1,0,0,1.
   - Required: out_tail=1 on the last two pairs; out_last only on the 6th pair.
   - Required: sys_sym on the first pair = -1024.
2. Same as scenario 1 with out_ready low for 3 cycles after the 2nd pair.
   - Required: the 3rd pair is held stable and in_ready=0 while stalled.
   - Required: the sequence is identical to scenario 1 and no pair is lost or duplicated.
3. Two frames back-to-back: 1,0,0,0 then 1,0,0,0.
   - Required: the second frame output exactly repeats the first (proves zero-state termination).
   - Required: in_ready=0 during both tail cycles.
4. Drive rst_n=0 asynchronously after 2 accepted bits.
   - Required: out_valid drops immediately.
   - Required: the next frame 1,0,0,0 produces the scenario 1 sequence.
5. All-zero frame.
   - Required: all sys/par=0, all symbols=+1024, 2 tail pairs of 0/0.
6. Random 1000 frames against a bit-accurate reference model under random in_valid/out_ready.
   - Required: exact match, final state zero after every out_last.
